// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory-mapped I/O responder: region decode and I/O widths.
package mem_io_pkg;

  localparam int unsigned IO_W = 10;

  // REG_UNMAPPED stands for every region code without a peripheral behind it
  typedef enum logic [3:0] {
    REG_RAM      = 4'h0,
    REG_LED      = 4'h1,
    REG_SW       = 4'h3,
    REG_TMR      = 4'h5,
    REG_UNMAPPED = 4'hF
  } region_e;

  localparam logic [15:0] REG_ERRCLR = 16'hF000;

  function automatic region_e decode_region(input logic [3:0] nib);
    case (nib)
      4'h0:    return REG_RAM;
      4'h1:    return REG_LED;
      4'h3:    return REG_SW;
      4'h5:    return REG_TMR;
      default: return REG_UNMAPPED;
    endcase
  endfunction

endpackage

// File: rtl/ram_1rw.sv
// Single-port synchronous word RAM, registered read, read-before-write.
// INIT_FILE is handed to the vendor flow through the ram_init_file attribute.
module ram_1rw #(
  parameter int unsigned RAM_AW    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter              INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam bit unused_init_given = (INIT_FILE != "");

  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [2**RAM_AW];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_io_responder.sv
// Bus responder: RAM, LED register, synchronised switches and prescaled timer, one-cycle read latency.
// Optional sticky unmapped-access flag on bus_err when MEM_IO_BUS_ERR_EN is defined.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned RAM_AW    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PRESCALE  = 50,
  parameter              INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] dout,
  input  logic              wren,
  output logic [DATA_W-1:0] din,
  input  logic [IO_W-1:0]   sw,
  output logic [IO_W-1:0]   ledr,
  output logic              bus_err
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  region_e           region;
  region_e           region_q;
  logic [IO_W-1:0]   sw_meta;
  logic [IO_W-1:0]   sw_sync;
  logic [15:0]       tmr_count;
  logic [PW-1:0]     presc;
  logic [DATA_W-1:0] periph_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic              unused_addr;

  assign region      = decode_region(addr[15:12]);
  assign ram_we      = wren && !resetn && (region == REG_RAM);
  assign unused_addr = ^addr[11:RAM_AW];

  ram_1rw #(
    .RAM_AW    (RAM_AW),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (addr[RAM_AW-1:0]),
    .wdata (dout),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (resetn) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      ledr      <= '0;
      tmr_count <= '0;
      presc     <= '0;
      periph_q  <= '0;
      region_q  <= REG_UNMAPPED;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      region_q <= region;

      // Peripheral read data is captured alongside the RAM read so both arrive together
      case (region)
        REG_LED: periph_q <= DATA_W'(ledr);
        REG_SW:  periph_q <= DATA_W'(sw_sync);
        REG_TMR: periph_q <= DATA_W'(tmr_count);
        default: periph_q <= '0;
      endcase

      if (wren && (region == REG_LED)) ledr <= dout[IO_W-1:0];

      if (wren && (region == REG_TMR)) begin
        tmr_count <= dout[15:0];
        presc     <= '0;
      end else if (presc == PW'(PRESCALE - 1)) begin
        presc     <= '0;
        tmr_count <= tmr_count + 16'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // region_q resets to unmapped, so din reads 0 right after reset regardless of RAM output
  assign din = (region_q == REG_RAM) ? ram_rdata : periph_q;

`ifdef MEM_IO_BUS_ERR_EN
  logic err_q;

  always_ff @(posedge clock) begin
    if (resetn) begin
      err_q <= 1'b0;
    end else if (wren) begin
      if ((addr == REG_ERRCLR) && (dout == DATA_W'(1))) err_q <= 1'b0;
      else if ((region == REG_UNMAPPED) || (region == REG_SW)) err_q <= 1'b1;
    end
  end

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed pins plus randomized traffic against a behavioural model.
module tb_mem_io_responder;

  localparam int P = 4;

  logic        clock  = 1'b0;
  logic        resetn = 1'b1;
  logic [15:0] addr   = '0;
  logic [15:0] dout   = '0;
  logic        wren   = 1'b0;
  logic [9:0]  sw     = '0;
  logic [15:0] din;
  logic [9:0]  ledr;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  mem_io_responder #(
    .RAM_AW    (8),
    .DATA_W    (16),
    .PRESCALE  (P),
    .INIT_FILE ("")
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .addr    (addr),
    .dout    (dout),
    .wren    (wren),
    .din     (din),
    .sw      (sw),
    .ledr    (ledr),
    .bus_err (bus_err)
  );

  always #5 clock = ~clock;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state of every addressable thing, updated once per rising edge
  logic [15:0] m_ram [256];
  bit          m_ok  [256];
  logic [9:0]  m_led, m_s1, m_s2;
  logic [15:0] m_cnt, m_din;
  int          m_pre;
  bit          m_err, din_known, started;

  always @(posedge clock) begin : model
    logic [3:0] r;
    r = addr[15:12];
    if (resetn) begin
      m_din = '0; din_known = 1'b1; m_led = '0; m_s1 = '0; m_s2 = '0;
      m_cnt = '0; m_pre = 0; m_err = 1'b0; started = 1'b1;
    end else begin
      din_known = 1'b1;
      case (r)
        4'h0: begin m_din = m_ram[addr[7:0]]; din_known = m_ok[addr[7:0]]; end
        4'h1: m_din = {6'b0, m_led};
        4'h3: m_din = {6'b0, m_s2};
        4'h5: m_din = m_cnt;
        default: m_din = '0;
      endcase
      m_s2 = m_s1;
      m_s1 = sw;
      if (wren && r == 4'h5) begin m_cnt = dout; m_pre = 0; end
      else if (m_pre == P - 1) begin m_pre = 0; m_cnt = m_cnt + 16'd1; end
      else m_pre = m_pre + 1;
      if (wren && r == 4'h1) m_led = dout[9:0];
      if (wren && r == 4'h0) begin m_ram[addr[7:0]] = dout; m_ok[addr[7:0]] = 1'b1; end
`ifdef MEM_IO_BUS_ERR_EN
      if (wren) begin
        if (addr == 16'hF000 && dout == 16'h0001) m_err = 1'b0;
        else if (!(r inside {4'h0, 4'h1, 4'h5})) m_err = 1'b1;
      end
`endif
    end
    #1;
    if (started) begin
      if (din_known) check16("model_din", din, m_din);
      check16("model_ledr", {6'b0, ledr}, {6'b0, m_led});
      check16("model_berr", {15'b0, bus_err}, {15'b0, m_err});
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r = 1'b0);
    @(negedge clock);
    addr = a; dout = d; wren = w; resetn = r;
  endtask

  initial begin
    logic [15:0] a, d;
    logic [3:0]  nib;
    int          sel;

    drive(16'h0000, 16'h0, 1'b0, 1'b1);
    drive(16'h0000, 16'h0, 1'b0, 1'b1);
    drive(16'h0000, 16'h0, 1'b0);
    check16("rst_din", din, 16'h0000);
    check16("rst_ledr", {6'b0, ledr}, 16'h0000);
    check16("rst_berr", {15'b0, bus_err}, 16'h0000);

    drive(16'h0012, 16'hBEEF, 1'b1);
    drive(16'h0012, 16'h0, 1'b0);
    drive(16'h0112, 16'h0, 1'b0);
    check16("ram_rd", din, 16'hBEEF);
    drive(16'h0000, 16'h0, 1'b0);
    check16("ram_alias", din, 16'hBEEF);

    drive(16'h0020, 16'h1111, 1'b1);
    drive(16'h0020, 16'h2222, 1'b1);
    drive(16'h0020, 16'h0, 1'b0);
    check16("rdw_old", din, 16'h1111);
    drive(16'h0000, 16'h0, 1'b0);
    check16("rdw_new", din, 16'h2222);

    drive(16'h1000, 16'h03FF, 1'b1);
    drive(16'h0000, 16'h0, 1'b0);
    check16("led_wr", {6'b0, ledr}, 16'h03FF);

    drive(16'h3000, 16'h0, 1'b0);
    sw = 10'h155;
    drive(16'h3000, 16'h0, 1'b0);
    drive(16'h3000, 16'h0, 1'b0);
    check16("sw_early", din, 16'h0000);
    drive(16'h3000, 16'h0, 1'b0);
    check16("sw_sync", din, 16'h0155);
    drive(16'h3000, 16'hFFFF, 1'b1);
    drive(16'h3000, 16'h0, 1'b0);
    drive(16'h0000, 16'h0, 1'b0);
    check16("sw_ro", din, 16'h0155);

    drive(16'h5000, 16'h0, 1'b0, 1'b1);
    repeat (4) drive(16'h5000, 16'h0, 1'b0);
    drive(16'h5000, 16'h0, 1'b0);
    check16("tmr_zero", din, 16'h0000);
    drive(16'h5000, 16'h0, 1'b0);
    check16("tmr_one", din, 16'h0001);
    drive(16'h5000, 16'hFFFF, 1'b1);
    repeat (4) drive(16'h5000, 16'h0, 1'b0);
    drive(16'h5000, 16'h0, 1'b0);
    check16("tmr_ffff", din, 16'hFFFF);
    drive(16'h5000, 16'h0, 1'b0);
    check16("tmr_wrap", din, 16'h0000);
    drive(16'h5000, 16'h0, 1'b0);
    drive(16'h5000, 16'h1234, 1'b1);
    drive(16'h5000, 16'h0, 1'b0);
    drive(16'h5000, 16'h0, 1'b0);
    check16("tmr_wr_wins", din, 16'h1234);
    drive(16'h5000, 16'h0, 1'b0);
    drive(16'h5000, 16'h0, 1'b0);
    drive(16'h5000, 16'h0, 1'b0);
    check16("tmr_presc_clr", din, 16'h1234);
    drive(16'h5000, 16'h0, 1'b0);
    check16("tmr_next_inc", din, 16'h1235);

    drive(16'h1000, 16'h002A, 1'b1);
    drive(16'h0005, 16'h55AA, 1'b1);
    check16("led_2a", {6'b0, ledr}, 16'h002A);
    drive(16'h0005, 16'h0000, 1'b1, 1'b1);
    drive(16'h0005, 16'h0, 1'b0);
    check16("mid_rst_ledr", {6'b0, ledr}, 16'h0000);
    check16("mid_rst_din", din, 16'h0000);
    drive(16'h5000, 16'h0, 1'b0);
    check16("mid_rst_ram", din, 16'h55AA);
    drive(16'h0000, 16'h0, 1'b0);
    check16("mid_rst_tmr", din, 16'h0000);

`ifdef MEM_IO_BUS_ERR_EN
    repeat (3) drive(16'h7000, 16'h0, 1'b0);
    drive(16'h7000, 16'h0001, 1'b1);
    check16("berr_rd", {15'b0, bus_err}, 16'h0000);
    drive(16'h0000, 16'h0, 1'b0);
    check16("berr_set", {15'b0, bus_err}, 16'h0001);
    drive(16'hF000, 16'h0001, 1'b1);
    drive(16'h0000, 16'h0, 1'b0);
    check16("berr_clr", {15'b0, bus_err}, 16'h0000);
`else
    drive(16'h7000, 16'h0001, 1'b1);
    drive(16'h0000, 16'h0, 1'b0);
    check16("berr_tied", {15'b0, bus_err}, 16'h0000);
`endif

    repeat (3000) begin
      sel = $urandom_range(0, 9);
      d   = 16'($urandom);
      case (sel)
        0, 1, 2, 3: a = {4'h0, 4'($urandom), 8'($urandom_range(0, 31))};
        4: a = {4'h1, 12'($urandom)};
        5: a = {4'h3, 12'($urandom)};
        6, 7: begin
          a = {4'h5, 12'($urandom)};
          if ($urandom_range(0, 1) == 0) d = 16'hFFFF - 16'($urandom_range(0, 3));
        end
        8: begin
          nib = 4'($urandom);
          for (int k = 0; k < 16 && (nib inside {4'h0, 4'h1, 4'h3, 4'h5}); k++) nib = 4'($urandom);
          if (nib inside {4'h0, 4'h1, 4'h3, 4'h5}) nib = 4'h7;
          a = {nib, 12'($urandom)};
        end
        default: begin
          a = 16'hF000;
          d = 16'($urandom_range(0, 2));
        end
      endcase
      drive(a, d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 199) == 0));
      if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
    end
    drive(16'h0000, 16'h0, 1'b0);
    drive(16'h0000, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Bus-side responder for the 16-bit processor's memory interface.
- Accepts the address/data-out/write-enable signals the control FSM drives (addr register, dout register, wren) and returns read data on din with a fixed one-cycle latency. This timing matches the FSM's T0 (address), T1 (wait), T2 (capture) fetch/load sequence.
- Contains word RAM, an LED output register, a synchronized switch input and a prescaled cycle timer, all memory-mapped.

Parameters:
- RAM_AW, 8, RAM address width in words (RAM depth = 2**RAM_AW).
- DATA_W, 16, bus data width.
- PRESCALE, 50, clock cycles per timer increment (must be >= 1).
- INIT_FILE, "", optional RAM init file (MIF/hex); empty means no init.

Ports:
- clock  in  1  system clock, all logic on the rising edge
- resetn  in  1  synchronous reset, ACTIVE-HIGH (1 = reset), sampled on the rising edge of clock
- addr  in  16  word address from the processor address register
- dout  in  DATA_W  write data from the processor dout register
- wren  in  1  write strobe, one cycle per store
- din  out  DATA_W  registered read data to the processor
- sw  in  10  raw board switches, asynchronous
- ledr  out  10  LED register
- bus_err  out  1  sticky unmapped-access flag; present only with BUS_ERR_EN, otherwise tied 0

Behaviour:
- Address map, decoded on addr[15:12]:
  - 0x0: RAM at addr[RAM_AW-1:0]; upper bits in the region are ignored (alias).
  - 0x1: LEDR; write ledr <= dout[9:0], read returns {6'b0, ledr}.
  - 0x3: SW, read-only; returns {6'b0, sw_sync}; writes are ignored.
  - 0x5: TIMER; read returns the count, write loads the count.
  - Any other region: unmapped; read returns 0x0000, write is ignored.
- Read latency:
  - din is registered. The value at edge N+1 reflects addr sampled at edge N.
  - din updates every cycle; there is no read strobe.
- Write: when wren=1 at edge N, dout is written into the region selected by addr at edge N.
- Read-during-write, same address: din returns the OLD data (read-before-write). The new value is visible one cycle later.
- Switch synchroniser: 2-flop, reset to 0. Switch change to visible on din takes 3 edges (2 sync plus 1 din register).
- Timer:
  - prescaler counts 0..PRESCALE-1; the 16-bit count increments when the prescaler wraps.
  - count wraps 0xFFFF -> 0x0000.
  - A write to TIMER at the same edge as an increment: the write wins, and the prescaler is cleared to 0.
- Reset (resetn=1 at an edge):
  - din=0, ledr=0, sw_sync=0, timer count=0, prescaler=0, bus_err=0.
  - RAM contents are preserved (not cleared).
  - A wren arriving together with reset is discarded, RAM included.
- Reset mid-operation: the first valid din is the value one edge after resetn returns to 0.
- No state machine is needed beyond the prescaler/timer counters; the responder is always ready (zero wait states).

Optional Feature:
- Macro MEM_IO_BUS_ERR_EN.
- Defined:
  - bus_err is set to 1 at the edge following any access to an unmapped region: a wren=1 to any unmapped address, or a write to SW.
  - A read of an unmapped region does NOT set it, because reads happen every cycle.
  - Sticky until reset. Writing 0x0001 to addr 0xF000 also clears it; this is the only writable unmapped address, and that write does not itself set the flag.
- Undefined: the port remains and is driven constant 0; no extra logic.

Decomposition:
- Package mem_io_pkg holds:
  - region codes REG_RAM=4'h0, REG_LED=4'h1, REG_SW=4'h3, REG_TMR=4'h5, REG_ERRCLR=16'hF000;
  - LED/SW width constant 10.
- One sub-module, ram_1rw: single-port synchronous RAM (RAM_AW, DATA_W, INIT_FILE), registered read with read-before-write, inferable as block RAM.
- Top handles decode, peripherals and the din mux. The din mux uses the region registered from the previous cycle, so the RAM output and peripheral outputs line up.

Test Plan:
- RAM write then read: write 0xBEEF to addr 0x0012, then drive addr 0x0012 -> din=0xBEEF one edge after the address is sampled; addr 0x0112 aliases to the same word (RAM_AW=8).
- Read-during-write: RAM[0x20]=0x1111; wren=1, dout=0x2222, addr=0x0020 -> din=0x1111 next edge, 0x2222 the edge after.
- LED and SW: write 0x03FF to 0x1000 -> ledr=10'h3FF; set sw=10'h155 -> din=0x0155 at addr 0x3000 exactly 3 edges after the switch change; a write to 0x3000 has no effect.
- Timer (PRESCALE=4): after reset, count=1 after 4 cycles; write 0xFFFF -> count becomes 0x0000 after 4 more cycles; a write coinciding with an increment loads the written value.
- Reset mid-run: ledr=0x2A, timer running, RAM[5]=0x55AA; assert resetn for 1 cycle -> ledr=0, din=0, timer=0, RAM[5] still 0x55AA.
- MEM_IO_BUS_ERR_EN: wren to 0x7000 -> bus_err=1 next edge; reads of 0x7000 never set it; write 0x0001 to 0xF000 -> bus_err=0.
